// File: rtl/touch_sensor_array.sv
// touch_sensor_array
//   Multi-channel capacitive touch front end. Each pad input is synchronised,
//   debounced, and turned into a clean level plus press/release/long-press
//   pulses and a per-channel toggle. Channels are fully independent; the only
//   shared output is any_touched.
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   touch_signal  raw asynchronous pad inputs, 1 = touched
//   touched       debounced level per channel
//   press_pulse   one-cycle pulse on each debounced 0->1
//   release_pulse one-cycle pulse on each debounced 1->0
//   long_press    one-cycle pulse when a hold reaches LONG_PRESS_CYCLES
//   toggle_state  flips on every press_pulse
//   any_touched   registered OR of touched, changes on the same edge as touched
module touch_sensor_array #(
  parameter int CHANNELS          = 4,
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int LONG_PRESS_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] touch_signal,
  output logic [CHANNELS-1:0] touched,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] toggle_state,
  output logic                any_touched
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

  logic [CHANNELS-1:0] sync_s1;
  logic [CHANNELS-1:0] sync_s2;
  logic [DB_W-1:0]     db_cnt   [CHANNELS];
  logic [LP_W-1:0]     hold_cnt [CHANNELS];

  // accept: s2 has disagreed with touched for DEBOUNCE_CYCLES samples in a row
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] touched_next;

  always_comb begin
    accept       = '0;
    touched_next = touched;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      accept[ch] = (sync_s2[ch] != touched[ch]) && (db_cnt[ch] == DB_LAST);
      if (accept[ch]) begin
        touched_next[ch] = sync_s2[ch];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_s1       <= '0;
      sync_s2       <= '0;
      touched       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      long_press    <= '0;
      toggle_state  <= '0;
      any_touched   <= 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        db_cnt[ch]   <= '0;
        hold_cnt[ch] <= '0;
      end
    end else begin
      sync_s1     <= touch_signal;
      sync_s2     <= sync_s1;
      touched     <= touched_next;
      any_touched <= |touched_next;

      for (int ch = 0; ch < CHANNELS; ch++) begin
        // Any sample agreeing with touched restarts the debounce window.
        if (sync_s2[ch] == touched[ch] || accept[ch]) begin
          db_cnt[ch] <= '0;
        end else begin
          db_cnt[ch] <= db_cnt[ch] + DB_W'(1);
        end

        press_pulse[ch]   <= accept[ch] &  sync_s2[ch];
        release_pulse[ch] <= accept[ch] & ~sync_s2[ch];

        if (accept[ch] && sync_s2[ch]) begin
          toggle_state[ch] <= ~toggle_state[ch];
        end

        // The hold counter looks at touched before this edge, so a release
        // landing on the terminal count still produces its long_press.
        if (!touched[ch]) begin
          hold_cnt[ch] <= '0;
        end else if (hold_cnt[ch] < LP_MAX) begin
          hold_cnt[ch] <= hold_cnt[ch] + LP_W'(1);
        end

        // Saturation at LP_MAX means this compare matches once per hold.
        long_press[ch] <= touched[ch] && (hold_cnt[ch] == LP_LAST);
      end
    end
  end

endmodule

// File: tb/tb_touch_sensor_array.sv
module tb_touch_sensor_array;

  localparam int CH = 4;
  localparam int DB = 4;
  localparam int LP = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] touch_signal = '0;
  logic [CH-1:0] touched;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] long_press;
  logic [CH-1:0] toggle_state;
  logic          any_touched;

  touch_sensor_array #(
    .CHANNELS(CH),
    .DEBOUNCE_CYCLES(DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .touch_signal(touch_signal),
    .touched(touched),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .toggle_state(toggle_state),
    .any_touched(any_touched)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] touched;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] lng;
    logic [CH-1:0] tog;
    logic          any;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Event tallies taken from the DUT by the monitor
  int press_cnt [CH];
  int rel_cnt   [CH];
  int long_cnt  [CH];
  int coin3_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a level is accepted once the synchronised input has held
  // one value for DB consecutive samples and differs from touched; long press
  // is a timestamp LP edges after the rise, valid if still touched.
  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_last = '0, m_touched = '0, m_tog = '0;
  int            m_age  [CH];
  int            m_rise [CH];
  int            edge_n = 0;

  task automatic model_step();
    exp_t e;
    logic s2p;
    e = '0;
    edge_n++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_last = '0; m_touched = '0; m_tog = '0;
      for (int c = 0; c < CH; c++) begin
        m_age[c]  = 0;
        m_rise[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        s2p = m_s2[c];
        if (s2p == m_last[c]) begin
          if (m_age[c] <= DB) m_age[c]++;
        end else begin
          m_age[c] = 1;
        end
        m_last[c] = s2p;
        if (m_touched[c] && edge_n == m_rise[c] + LP) e.lng[c] = 1'b1;
        if (m_age[c] == DB && s2p != m_touched[c]) begin
          m_touched[c] = s2p;
          if (s2p) begin
            e.press[c] = 1'b1;
            m_tog[c]   = ~m_tog[c];
            m_rise[c]  = edge_n;
          end else begin
            e.rel[c] = 1'b1;
          end
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = touch_signal[c];
      end
    end
    e.touched = m_touched;
    e.tog     = m_tog;
    e.any     = |m_touched;
    exp_q.push_back(e);
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_age[c] = 0; m_rise[c] = 0;
      press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compare every DUT output against the queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("touched",       32'(touched),       32'(e.touched));
        chk("press_pulse",   32'(press_pulse),   32'(e.press));
        chk("release_pulse", 32'(release_pulse), 32'(e.rel));
        chk("long_press",    32'(long_press),    32'(e.lng));
        chk("toggle_state",  32'(toggle_state),  32'(e.tog));
        chk("any_touched",   32'(any_touched),   32'(e.any));
        for (int c = 0; c < CH; c++) begin
          press_cnt[c] += int'(press_pulse[c]);
          rel_cnt[c]   += int'(release_pulse[c]);
          long_cnt[c]  += int'(long_press[c]);
        end
        coin3_cnt += int'(long_press[3] & release_pulse[3]);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stimulus
    int base_a, base_b;
    logic [7:0] bounce;

    // Input held high through reset, then a fresh press on every channel
    rst = 1'b1; touch_signal = '1;
    run(3);
    rst = 1'b0;
    run(20);
    touch_signal = '0;
    run(25);

    // Glitch shorter than the debounce window on ch0
    base_a = press_cnt[0]; base_b = rel_cnt[0];
    touch_signal[0] = 1'b1; run(3);
    touch_signal[0] = 1'b0; run(12);
    chk("glitch_press0",   32'(press_cnt[0] - base_a), 32'd0);
    chk("glitch_release0", 32'(rel_cnt[0] - base_b),   32'd0);

    // Bounce on ch1 restarts the count; one press only
    base_a = press_cnt[1];
    bounce = 8'b1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1
    for (int i = 0; i < 8; i++) begin
      touch_signal[1] = bounce[i];
      run(1);
    end
    run(10);
    chk("bounce_press1", 32'(press_cnt[1] - base_a), 32'd1);
    touch_signal[1] = 1'b0;
    run(12);

    // Long hold on ch2: one long press, one release
    base_a = long_cnt[2]; base_b = rel_cnt[2];
    touch_signal[2] = 1'b1; run(20);
    touch_signal[2] = 1'b0; run(16);
    chk("long2_count",    32'(long_cnt[2] - base_a), 32'd1);
    chk("long2_release",  32'(rel_cnt[2] - base_b),  32'd1);

    // ch3 held so the debounced fall lands on the long-press edge
    base_a = coin3_cnt;
    touch_signal[3] = 1'b1; run(10);
    touch_signal[3] = 1'b0; run(16);
    chk("coincident_long_release3", 32'(coin3_cnt - base_a), 32'd1);

    // Toggle on ch0 from a clean reset
    rst = 1'b1; run(2);
    rst = 1'b0; run(2);
    touch_signal[0] = 1'b1; run(8);
    touch_signal[0] = 1'b0; run(8);
    chk("toggle0_first",  32'(toggle_state[0]), 32'd1);
    touch_signal[0] = 1'b1; run(8);
    touch_signal[0] = 1'b0; run(8);
    chk("toggle0_second", 32'(toggle_state[0]), 32'd0);

    // Random slow-changing inputs with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) touch_signal[c] = ~touch_signal[c];
      end
      run(1);
    end
    rst = 1'b0;
    run(3);
    chk("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
